// File: rtl/time_keeper.sv
// time_keeper: packed-BCD hh:mm:ss timekeeper advanced by an asynchronous 1 Hz tick.
// The tick is synchronised, then edge-detected. Clear, load and tick are arbitrated
// per cycle with that priority. The optional alarm is compiled in only when the
// macro TIME_KEEPER_ALARM_EN is defined. Otherwise the alarm ports remain and
// alarm is tied low.
module time_keeper #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_on,
    input  logic       alarm_ack,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       set_err,
    output logic       alarm
);

    // Each function returns the next digit pair, with the carry-out in bit 8.
    // The units digit rolls 9 -> 0 and the tens digit rolls 5 -> 0.
    function automatic logic [8:0] inc_base60(input logic [7:0] v);
        logic [8:0] r;
        if (v[3:0] != 4'd9) begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end else if (v[7:4] != 4'd5) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b1, 8'h00};
        end
        return r;
    endfunction

    // Hours wrap 23 -> 00. Otherwise they follow the plain decimal carry.
    function automatic logic [8:0] inc_hours(input logic [7:0] v);
        logic [8:0] r;
        if (v == 8'h23) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] != 4'd9) begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end else begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   w_tick_rise;
    logic                   w_inc;
    logic                   w_set_ok;

    logic [7:0] r_hh;
    logic [7:0] r_mm;
    logic [7:0] r_ss;
    logic       r_sec;
    logic       r_day;
    logic       r_err;

    logic [8:0] w_ss_inc;
    logic [8:0] w_mm_inc;
    logic [8:0] w_hh_inc;
    logic [7:0] w_hh_next;
    logic [7:0] w_mm_next;
    logic [7:0] w_ss_next;
    logic       w_day_next;
    logic       w_err_next;

    // The synchroniser and edge flops track tick_in regardless of run.
    // As a result, a tick that arrives while time is held is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick_rise = r_sync[SYNC_STAGES-1] & ~r_edge;

    // A tick counts only when run is high and neither clear nor load claims the cycle.
    assign w_inc = w_tick_rise & run & ~clear & ~load;

    // A load is accepted only when every digit is in range and the hour is at most 23.
    assign w_set_ok = (set_ss[3:0] <= 4'd9) && (set_ss[7:4] <= 4'd5) &&
                      (set_mm[3:0] <= 4'd9) && (set_mm[7:4] <= 4'd5) &&
                      (set_hh[3:0] <= 4'd9) && (set_hh <= 8'h23);

    assign w_ss_inc = inc_base60(r_ss);
    assign w_mm_inc = inc_base60(r_mm);
    assign w_hh_inc = inc_hours(r_hh);

    // Next-time arbitration: clear beats load, and load beats tick.
    always_comb begin
        w_hh_next  = r_hh;
        w_mm_next  = r_mm;
        w_ss_next  = r_ss;
        w_day_next = 1'b0;
        w_err_next = 1'b0;
        if (clear) begin
            w_hh_next = 8'h00;
            w_mm_next = 8'h00;
            w_ss_next = 8'h00;
        end else if (load) begin
            if (w_set_ok) begin
                w_hh_next = set_hh;
                w_mm_next = set_mm;
                w_ss_next = set_ss;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (w_inc) begin
            w_ss_next = w_ss_inc[7:0];
            if (w_ss_inc[8]) begin
                w_mm_next = w_mm_inc[7:0];
                if (w_mm_inc[8]) begin
                    w_hh_next  = w_hh_inc[7:0];
                    w_day_next = w_hh_inc[8];
                end
            end
        end
    end

    // Register the time and the single-cycle strobes so that every output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hh  <= 8'h00;
            r_mm  <= 8'h00;
            r_ss  <= 8'h00;
            r_sec <= 1'b0;
            r_day <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_hh  <= w_hh_next;
            r_mm  <= w_mm_next;
            r_ss  <= w_ss_next;
            r_sec <= w_inc;
            r_day <= w_day_next;
            r_err <= w_err_next;
        end
    end

    assign hh        = r_hh;
    assign mm        = r_mm;
    assign ss        = r_ss;
    assign sec_pulse = r_sec;
    assign day_pulse = r_day;
    assign set_err   = r_err;

`ifdef TIME_KEEPER_ALARM_EN
    logic r_alarm;
    logic w_alarm_set;
    logic w_alarm_clr;

    // Only a counted increment can arm the alarm. A load that lands on the alarm time does not.
    assign w_alarm_set = w_inc & alarm_on & (w_hh_next == alarm_hh) &
                         (w_mm_next == alarm_mm) & (w_ss_next == 8'h00);

    // A change of minute matters only once the alarm is already ringing.
    // Otherwise the minute rollover that arms the alarm would also clear it.
    assign w_alarm_clr = alarm_ack | ~alarm_on | (r_alarm & (w_mm_next != r_mm));

    // Alarm latch: clear takes precedence over set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_clr) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_set) begin
            r_alarm <= 1'b1;
        end
    end

    assign alarm = r_alarm;
`else
    logic w_unused_alarm;

    assign w_unused_alarm = ^{alarm_hh, alarm_mm, alarm_on, alarm_ack};
    assign alarm          = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper. A seconds-of-day reference model runs every cycle.
// Directed sequences and a table of load vectors are checked against that model
// and also against constants.
module tb_time_keeper;

    localparam int SS_N = 2;
`ifdef TIME_KEEPER_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       run = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;
    logic       alarm_on = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_pulse;
    logic       day_pulse;
    logic       set_err;
    logic       alarm;

    int checks = 0;
    int errors = 0;
    int n_sec  = 0;

    // Reference model state: time as seconds of day, plus tick_in samples from past clock edges.
    int m_t;
    bit m_sec;
    bit m_day;
    bit m_err;
    bit m_alarm;
    bit m_past[0:4];

    always #5 clk = ~clk;

    time_keeper #(.SYNC_STAGES(SS_N)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .run(run), .clear(clear),
        .load(load), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_on(alarm_on),
        .alarm_ack(alarm_ack), .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse),
        .day_pulse(day_pulse), .set_err(set_err), .alarm(alarm)
    );

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Each digit must be a decimal digit, minutes and seconds must be below 60, and hours below 24.
    function automatic bit set_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bit ok;
        ok = (h[3:0] < 10) && (m[3:0] < 10) && (s[3:0] < 10);
        ok = ok && (bcd2i(m) < 60) && (bcd2i(s) < 60) && (bcd2i(h) < 24);
        return ok;
    endfunction

    task automatic model_reset();
        m_t = 0; m_sec = 0; m_day = 0; m_err = 0; m_alarm = 0;
        for (int i = 0; i < 5; i++) m_past[i] = 0;
    endtask

    task automatic model_posedge();
        bit rise;
        bit a_set;
        bit a_clr;
        int old_min;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise = m_past[SS_N-1] && !m_past[SS_N];
        for (int i = 4; i > 0; i--) m_past[i] = m_past[i-1];
        m_past[0] = tick_in;
        old_min = (m_t / 60) % 60;
        m_sec = 0; m_day = 0; m_err = 0;
        if (clear) m_t = 0;
        else if (load) begin
            if (set_valid(set_hh, set_mm, set_ss))
                m_t = bcd2i(set_hh) * 3600 + bcd2i(set_mm) * 60 + bcd2i(set_ss);
            else
                m_err = 1;
        end else if (rise && run) begin
            m_t   = (m_t + 1) % 86400;
            m_sec = 1;
            m_day = (m_t == 0);
        end
        if (ALARM_EN) begin
            a_set = m_sec && alarm_on && (m_t == bcd2i(alarm_hh) * 3600 + bcd2i(alarm_mm) * 60);
            a_clr = alarm_ack || !alarm_on || (m_alarm && ((m_t / 60) % 60 != old_min));
            m_alarm = a_clr ? 1'b0 : (a_set ? 1'b1 : m_alarm);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("hh", hh, i2bcd(m_t / 3600));
        chk("mm", mm, i2bcd((m_t / 60) % 60));
        chk("ss", ss, i2bcd(m_t % 60));
        chk("sec_pulse", {7'd0, sec_pulse}, {7'd0, m_sec});
        chk("day_pulse", {7'd0, day_pulse}, {7'd0, m_day});
        chk("set_err", {7'd0, set_err}, {7'd0, m_err});
        chk("alarm", {7'd0, alarm}, {7'd0, m_alarm});
    endtask

    // Inputs are driven before the rising edge. Outputs are compared at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        model_posedge();
        @(negedge clk);
        if (sec_pulse === 1'b1) n_sec++;
        compare_all();
    endtask

    task automatic do_tick(output bit saw_sec, output bit saw_day);
        saw_sec = 0;
        saw_day = 0;
        tick_in = 1'b1;
        repeat (SS_N + 1) begin
            cycle();
            if (sec_pulse === 1'b1) saw_sec = 1;
            if (day_pulse === 1'b1) saw_day = 1;
        end
        tick_in = 1'b0;
        repeat (2) begin
            cycle();
            if (sec_pulse === 1'b1) saw_sec = 1;
            if (day_pulse === 1'b1) saw_day = 1;
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; set_hh = h; set_mm = m; set_ss = s;
        cycle();
        load = 1'b0;
    endtask

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        bit         err;
        logic [7:0] eh;
        logic [7:0] em;
        logic [7:0] es;
    } load_vec_t;

    load_vec_t vecs[10];

    initial begin
        bit         sa;
        bit         da;
        logic [7:0] prev;
        int         t;
        int         nm;

        vecs[0] = '{8'h12, 8'h60, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'h24, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h12, 8'h34, 8'h56, 1'b0, 8'h12, 8'h34, 8'h56};
        vecs[3] = '{8'h09, 8'h59, 8'h5A, 1'b1, 8'h12, 8'h34, 8'h56};
        vecs[4] = '{8'h19, 8'h45, 8'h30, 1'b0, 8'h19, 8'h45, 8'h30};
        vecs[5] = '{8'h23, 8'h59, 8'h59, 1'b0, 8'h23, 8'h59, 8'h59};
        vecs[6] = '{8'h2A, 8'h00, 8'h00, 1'b1, 8'h23, 8'h59, 8'h59};
        vecs[7] = '{8'h00, 8'h00, 8'h60, 1'b1, 8'h23, 8'h59, 8'h59};
        vecs[8] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[9] = '{8'h0F, 8'h10, 8'h10, 1'b1, 8'h00, 8'h00, 8'h00};

        model_reset();

        // Reset state.
        repeat (2) cycle();
        chk("reset_hh", hh, 8'h00);
        chk("reset_ss", ss, 8'h00);
        chk("reset_sec", {7'd0, sec_pulse}, 8'h00);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Three ticks. Each one takes effect SS_N+1 edges after tick_in is sampled high.
        n_sec = 0;
        for (int k = 1; k <= 3; k++) begin
            prev = ss;
            tick_in = 1'b1;
            cycle();
            chk("lat_e1", ss, prev);
            cycle();
            chk("lat_e2", ss, prev);
            cycle();
            chk("lat_e3", ss, i2bcd(k));
            chk("lat_sec", {7'd0, sec_pulse}, 8'h01);
            tick_in = 1'b0;
            repeat (3) cycle();
        end
        chk("sec_count", 8'(n_sec), 8'd3);
        chk("ss_after3", ss, 8'h03);

        // Day wrap.
        do_load(8'h23, 8'h59, 8'h58);
        do_tick(sa, da);
        chk("wrap1_ss", ss, 8'h59);
        chk("wrap1_day", {7'd0, da}, 8'h00);
        do_tick(sa, da);
        chk("wrap2_hh", hh, 8'h00);
        chk("wrap2_mm", mm, 8'h00);
        chk("wrap2_ss", ss, 8'h00);
        chk("wrap2_sec", {7'd0, sa}, 8'h01);
        chk("wrap2_day", {7'd0, da}, 8'h01);

        // Load vectors, including rejected ones.
        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].h, vecs[i].m, vecs[i].s);
            chk("vec_err", {7'd0, set_err}, {7'd0, vecs[i].err});
            chk("vec_hh", hh, vecs[i].eh);
            chk("vec_mm", mm, vecs[i].em);
            chk("vec_ss", ss, vecs[i].es);
            cycle();
            chk("vec_err_1cyc", {7'd0, set_err}, 8'h00);
            chk("vec_ss_hold", ss, vecs[i].es);
        end

        // A tick that coincides with a load is discarded.
        tick_in = 1'b1;
        cycle();
        cycle();
        do_load(8'h12, 8'h34, 8'h56);
        chk("tl_hh", hh, 8'h12);
        chk("tl_ss", ss, 8'h56);
        chk("tl_sec", {7'd0, sec_pulse}, 8'h00);
        tick_in = 1'b0;
        repeat (3) cycle();
        chk("tl_not_deferred", ss, 8'h56);

        // A tick that coincides with a clear is discarded.
        tick_in = 1'b1;
        cycle();
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("tc_ss", ss, 8'h00);
        chk("tc_sec", {7'd0, sec_pulse}, 8'h00);
        tick_in = 1'b0;
        repeat (3) cycle();
        do_load(8'h12, 8'h34, 8'h56);

        // While run is low, ticks are dropped.
        run = 1'b0;
        do_tick(sa, da);
        do_tick(sa, da);
        run = 1'b1;
        chk("hold_ss", ss, 8'h56);
        chk("hold_mm", mm, 8'h34);
        repeat (4) cycle();
        chk("hold_no_defer", ss, 8'h56);

        // Reset mid-count, with a tick in flight.
        do_load(8'h05, 8'h06, 8'h07);
        tick_in = 1'b1;
        cycle();
        rst_n = 1'b0;
        tick_in = 1'b0;
        #1;
        model_reset();
        chk("async_hh", hh, 8'h00);
        chk("async_mm", mm, 8'h00);
        chk("async_ss", ss, 8'h00);
        cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        chk("post_rst_ss", ss, 8'h00);
        do_tick(sa, da);
        chk("post_rst_tick", ss, 8'h01);

        // A tick_in already high at reset release counts once it has been synchronised.
        tick_in = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        chk("rel_high_wait", ss, 8'h00);
        cycle();
        chk("rel_high_ss", ss, 8'h01);
        tick_in = 1'b0;
        repeat (3) cycle();

        // Alarm behaviour.
        alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_on = 1'b1;
        do_load(8'h07, 8'h29, 8'h59);
        chk("alm_pre", {7'd0, alarm}, 8'h00);
        do_tick(sa, da);
        chk("alm_set", {7'd0, alarm}, {7'd0, ALARM_EN});
        do_tick(sa, da);
        chk("alm_hold", {7'd0, alarm}, {7'd0, ALARM_EN});
        alarm_ack = 1'b1;
        cycle();
        alarm_ack = 1'b0;
        chk("alm_ack", {7'd0, alarm}, 8'h00);
        do_load(8'h07, 8'h30, 8'h00);
        chk("alm_load_no_set", {7'd0, alarm}, 8'h00);
        do_load(8'h07, 8'h29, 8'h59);
        alarm_ack = 1'b1;
        do_tick(sa, da);
        alarm_ack = 1'b0;
        chk("alm_clr_wins", {7'd0, alarm}, 8'h00);
        do_load(8'h07, 8'h29, 8'h59);
        do_tick(sa, da);
        chk("alm_set2", {7'd0, alarm}, {7'd0, ALARM_EN});
        do_load(8'h07, 8'h31, 8'h00);
        chk("alm_mm_clr", {7'd0, alarm}, 8'h00);
        do_load(8'h07, 8'h29, 8'h59);
        do_tick(sa, da);
        alarm_on = 1'b0;
        cycle();
        chk("alm_off_clr", {7'd0, alarm}, 8'h00);

        // Randomised traffic, checked against the model on every cycle.
        for (int n = 0; n < 4000; n++) begin
            clear = 1'b0;
            load  = 1'b0;
            if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
            run       = ($urandom_range(0, 7) != 0);
            alarm_on  = ($urandom_range(0, 29) != 0);
            alarm_ack = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 63) == 0) clear = 1'b1;
            if ($urandom_range(0, 23) == 0) begin
                load = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    set_hh = 8'($urandom);
                    set_mm = 8'($urandom);
                    set_ss = 8'($urandom);
                end else begin
                    t = $urandom_range(0, 86399);
                    if ($urandom_range(0, 1) == 1) t = (t / 60) * 60 + 55;
                    if ($urandom_range(0, 7) == 0) t = 86395;
                    set_hh = i2bcd(t / 3600);
                    set_mm = i2bcd((t / 60) % 60);
                    set_ss = i2bcd(t % 60);
                    if ($urandom_range(0, 1) == 1) begin
                        nm = (t / 60 + 1) % 1440;
                        alarm_hh = i2bcd(nm / 60);
                        alarm_mm = i2bcd(nm % 60);
                    end
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchroniser flops on tick_in; legal range 2..4.
REQ-002 SHALL have port clk  in  1: the single system clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-004 SHALL have port tick_in  in  1: 1 Hz square wave from the upstream seconds divider; may be asynchronous to clk.
REQ-005 SHALL have port run  in  1: 1 = count seconds, 0 = hold time.
REQ-006 SHALL have port clear  in  1: synchronous zero of the time.
REQ-007 SHALL have port load  in  1: load set_hh/set_mm/set_ss this cycle.
REQ-008 SHALL have ports set_hh, set_mm, set_ss  in  8 each: packed BCD {tens, units}.
REQ-009 SHALL have ports hh, mm, ss  out  8 each: current time, packed BCD.
REQ-010 SHALL have port sec_pulse  out  1: one-cycle strobe on each seconds increment.
REQ-011 SHALL have port day_pulse  out  1: one-cycle strobe on the 23:59:59 -> 00:00:00 wrap.
REQ-012 SHALL have port set_err  out  1: one-cycle strobe when a load is rejected.
REQ-013 SHALL have ports alarm_hh, alarm_mm  in  8 each, alarm_on  in  1, alarm_ack  in  1, alarm  out  1: see Configuration.

Function
REQ-014 SHALL pass tick_in through SYNC_STAGES flops, then one edge register; tick_rise = last sync stage high AND edge register low.
REQ-015 SHALL update ss on the clk edge at which tick_rise is 1, i.e. SYNC_STAGES+1 clk edges after tick_in is first sampled high.
REQ-016 SHALL count only rising edges of tick_in; a falling edge has no effect.
REQ-017 SHALL keep the sync/edge flops tracking while run=0, so a tick that arrives while held is dropped, not deferred.
REQ-018 SHALL apply the following increment rules:
- seconds units 9 -> 0 with carry into tens;
- seconds tens 5 -> 0 with carry into minutes;
- minutes follow the same rules;
- hours 23 -> 00.
REQ-019 SHALL keep every BCD digit in range at all times; no binary intermediate value is visible on the outputs.
REQ-020 SHALL assert sec_pulse for exactly one cycle on each accepted increment.
REQ-021 SHALL assert day_pulse in the same cycle as sec_pulse when the time wraps to 00:00:00.
REQ-022 SHALL apply priority per cycle: clear > load > tick. A tick that coincides with clear or load is discarded, and no sec_pulse is produced.
REQ-023 SHALL load only when all digits are valid: each unit digit <= 9, set_ss and set_mm tens <= 5, set_hh <= 0x23.
REQ-024 SHALL, when any digit is invalid, leave the time unchanged and pulse set_err for one cycle.
REQ-025 SHALL make loaded or cleared values visible on hh/mm/ss on the clk edge that samples load or clear.
REQ-026 SHALL drive all outputs from registers; no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force:
- hh/mm/ss to 0x00;
- sec_pulse, day_pulse, set_err and alarm to 0;
- all synchroniser and edge flops to 0.
REQ-028 SHALL resume counting on the first tick_rise after rst_n deasserts; a tick_in already high at release counts as one rising edge once it has been synchronised.
REQ-029 SHALL abandon any in-flight tick when reset asserts mid-operation; no increment occurs after release without a new synchronised high.

Configuration
REQ-030 SHALL implement the alarm only when macro TIME_KEEPER_ALARM_EN is defined.
REQ-031 SHALL, with TIME_KEEPER_ALARM_EN defined, behave as follows:
- alarm sets on the increment that produces hh==alarm_hh, mm==alarm_mm, ss==0x00 while alarm_on=1;
- alarm stays set until alarm_ack=1, alarm_on=0, or mm changes; clearing occurs on that clk edge;
- if set and clear occur in the same cycle, clear wins;
- a load that lands on the alarm time does not set alarm.
REQ-032 SHALL, without TIME_KEEPER_ALARM_EN, keep all alarm ports present, ignore the alarm inputs and tie alarm to 0.

Verification
REQ-033 SHALL cover: reset, then 3 tick_in rising edges with run=1 -> ss=0x03 and 3 sec_pulse; each ss update 3 clk edges after tick_in is sampled high (SYNC_STAGES=2).
REQ-034 SHALL cover: load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00; day_pulse high only in the second sec_pulse cycle.
REQ-035 SHALL cover: load set_mm=0x60 -> set_err for one cycle, time unchanged; load 0x24:00:00 -> set_err for one cycle.
REQ-036 SHALL cover: tick_rise coinciding with load 12:34:56 -> time 12:34:56, no sec_pulse; run=0 for 2 ticks -> time unchanged.
REQ-037 SHALL cover: rst_n pulsed low for 1 cycle mid-count at 05:06:07 -> outputs 0x00 immediately, no increment after release until the next tick_in rising edge.
REQ-038 SHALL cover: TIME_KEEPER_ALARM_EN defined, alarm 07:30, load 07:29:59, 1 tick -> alarm=1; alarm_ack pulse -> alarm=0 the next edge; macro undefined -> alarm stays 0.
